// File: rtl/carfield_mailbox_responder_pkg.sv
// carfield_mailbox_pkg
// Shared definitions for the Carfield mailbox responder:
//   - register offsets inside one mailbox window
//   - size of one mailbox window
//   - per-mailbox register bundle type
//   - handshake FSM state encoding
//   - byte-strobe merge helper
package carfield_mailbox_pkg;

  localparam logic [7:0] OFF_LETTER0  = 8'h00;
  localparam logic [7:0] OFF_LETTER1  = 8'h04;
  localparam logic [7:0] OFF_DOORBELL = 8'h08;
  localparam logic [7:0] OFF_COMPLETE = 8'h0C;
  localparam logic [7:0] OFF_IRQ_EN   = 8'h10;
  localparam logic [7:0] OFF_DONE_CLR = 8'h14;

  localparam int unsigned MboxWinSize = 32'h0000_0100;

  typedef struct packed {
    logic [31:0] letter0;
    logic [31:0] letter1;
    logic        pending;
    logic        overrun;
    logic        done;
    logic        rcv_en;
    logic        snd_en;
  } mbox_reg_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  // Merge write data into an existing word, one byte per strobe bit.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) begin
        res[8*b +: 8] = wdata[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_val[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/carfield_mailbox_responder_if.sv
// carfield_mailbox_responder_if
// Simple request/response bus between the AXI bridge and the mailbox responder.
//   req_*  : request channel (valid/ready, address, write flag, data, strobes)
//   rsp_*  : response channel (valid/ready, read data, decode error)
// Modports: master = bridge side, slave = responder side.
interface carfield_mailbox_responder_if #(
  parameter int unsigned AddrWidth = 48
);
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [AddrWidth-1:0] req_addr_i;
  logic                 req_write_i;
  logic [31:0]          req_wdata_i;
  logic [3:0]           req_wstrb_i;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [31:0]          rsp_rdata_o;
  logic                 rsp_error_o;

  modport master (
    output req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_wstrb_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_wstrb_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o
  );
endinterface

// File: rtl/carfield_mailbox_responder_unit.sv
// carfield_mailbox_unit
// Register file of one mailbox: two letter words, doorbell/complete flags,
// interrupt enables.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_wr_en      : write strobe, already qualified by decode (no error)
//   i_off        : register offset inside the mailbox window
//   i_wdata/i_wstrb : write data and byte strobes
//   o_rdata      : read data for i_off
//   o_hit        : i_off names a mapped register
//   o_rcv_irq/o_snd_irq : doorbell / completion interrupts
module carfield_mailbox_unit
  import carfield_mailbox_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr_en,
  input  logic [7:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  output logic [31:0] o_rdata,
  output logic        o_hit,
  output logic        o_rcv_irq,
  output logic        o_snd_irq
);

  mbox_reg_t r_regs;

  // Register update; flag registers only honour wstrb[0].
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_regs <= '0;
    end else if (i_wr_en) begin
      case (i_off)
        OFF_LETTER0: r_regs.letter0 <= apply_wstrb(r_regs.letter0, i_wdata, i_wstrb);
        OFF_LETTER1: r_regs.letter1 <= apply_wstrb(r_regs.letter1, i_wdata, i_wstrb);
        OFF_DOORBELL: begin
          if (i_wstrb[0] && i_wdata[0]) begin
            // A second ring before completion is recorded as overrun.
            r_regs.overrun <= r_regs.overrun | r_regs.pending;
            r_regs.pending <= 1'b1;
            r_regs.done    <= 1'b0;
          end
        end
        OFF_COMPLETE: begin
          if (i_wstrb[0] && i_wdata[0]) begin
            r_regs.pending <= 1'b0;
            r_regs.done    <= 1'b1;
          end
          if (i_wstrb[0] && i_wdata[1]) begin
            r_regs.overrun <= 1'b0;
          end
        end
        OFF_IRQ_EN: begin
          if (i_wstrb[0]) begin
            r_regs.rcv_en <= i_wdata[0];
            r_regs.snd_en <= i_wdata[1];
          end
        end
        OFF_DONE_CLR: begin
          if (i_wstrb[0] && i_wdata[0]) begin
            r_regs.done <= 1'b0;
          end
        end
        default: r_regs <= r_regs;
      endcase
    end else begin
      r_regs <= r_regs;
    end
  end

  // Read mux and offset-valid flag.
  always_comb begin
    o_rdata = 32'h0000_0000;
    o_hit   = 1'b1;
    case (i_off)
      OFF_LETTER0:  o_rdata = r_regs.letter0;
      OFF_LETTER1:  o_rdata = r_regs.letter1;
      OFF_DOORBELL: o_rdata = {30'b0, r_regs.overrun, r_regs.pending};
      OFF_COMPLETE: o_rdata = {31'b0, r_regs.done};
      OFF_IRQ_EN:   o_rdata = {30'b0, r_regs.snd_en, r_regs.rcv_en};
      OFF_DONE_CLR: o_rdata = 32'h0000_0000;
      default: begin
        o_rdata = 32'h0000_0000;
        o_hit   = 1'b0;
      end
    endcase
  end

  // Interrupts come straight from flops, no input path.
  assign o_rcv_irq = r_regs.pending & r_regs.rcv_en;
  assign o_snd_irq = r_regs.done & r_regs.snd_en;

endmodule

// File: rtl/carfield_mailbox_responder.sv
// carfield_mailbox_responder
// Mailbox window responder: decodes requests, routes them to NumMbox mailbox
// units and returns one response per request through a two-state handshake.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : request/response bus (slave side)
//   rcv_irq_o    : per-mailbox doorbell interrupt
//   snd_irq_o    : per-mailbox completion interrupt
module carfield_mailbox_responder
  import carfield_mailbox_pkg::*;
#(
  parameter int unsigned          NumMbox   = 4,
  parameter int unsigned          AddrWidth = 48,
  parameter logic [AddrWidth-1:0] MboxBase  = AddrWidth'(32'h4000_0000),
  parameter logic [AddrWidth-1:0] MboxSize  = AddrWidth'(32'h0000_1000)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  carfield_mailbox_responder_if.slave  bus,
  output logic [NumMbox-1:0]           rcv_irq_o,
  output logic [NumMbox-1:0]           snd_irq_o
);

  localparam logic [AddrWidth-1:0] MboxSpan = AddrWidth'(NumMbox * MboxWinSize);

  state_e               r_state;
  state_e               w_state_next;
  logic [31:0]          r_rdata;
  logic                 r_error;

  logic [AddrWidth-1:0] w_off;
  logic [3:0]           w_idx;
  logic                 w_accept;
  logic                 w_err;
  logic [31:0]          w_sel_rdata;
  logic                 w_sel_hit;
  logic [31:0]          w_unit_rdata [NumMbox];
  logic [NumMbox-1:0]   w_unit_hit;
  logic [NumMbox-1:0]   w_unit_wr;

  assign w_off    = bus.req_addr_i - MboxBase;
  assign w_idx    = w_off[11:8];
  assign w_accept = bus.req_valid_i & (r_state == IDLE);

  // Select the addressed mailbox's read data and offset-valid flag.
  always_comb begin
    w_sel_rdata = 32'h0000_0000;
    w_sel_hit   = 1'b0;
    for (int i = 0; i < NumMbox; i++) begin
      if (w_idx == 4'(i)) begin
        w_sel_rdata = w_unit_rdata[i];
        w_sel_hit   = w_unit_hit[i];
      end else begin
        w_sel_rdata = w_sel_rdata;
        w_sel_hit   = w_sel_hit;
      end
    end
  end

  // Decode error: outside the window, beyond the last mailbox, misaligned,
  // or unmapped register offset.
  assign w_err = (bus.req_addr_i < MboxBase) | (w_off >= MboxSize) |
                 (w_off >= MboxSpan) | (bus.req_addr_i[1:0] != 2'b00) | ~w_sel_hit;

  for (genvar g = 0; g < NumMbox; g++) begin : g_mbox
    assign w_unit_wr[g] = w_accept & bus.req_write_i & ~w_err & (w_idx == 4'(g));

    carfield_mailbox_unit u_unit (
      .i_clk     (clk_i),
      .i_rst     (rst_i),
      .i_wr_en   (w_unit_wr[g]),
      .i_off     (w_off[7:0]),
      .i_wdata   (bus.req_wdata_i),
      .i_wstrb   (bus.req_wstrb_i),
      .o_rdata   (w_unit_rdata[g]),
      .o_hit     (w_unit_hit[g]),
      .o_rcv_irq (rcv_irq_o[g]),
      .o_snd_irq (snd_irq_o[g])
    );
  end

  // Handshake next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.req_valid_i) w_state_next = RESP;
        else                 w_state_next = IDLE;
      end
      RESP: begin
        if (bus.rsp_ready_i) w_state_next = IDLE;
        else                 w_state_next = RESP;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register and response latch; rdata is 0 on writes and errors.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_rdata <= 32'h0000_0000;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_rdata <= (w_err | bus.req_write_i) ? 32'h0000_0000 : w_sel_rdata;
        r_error <= w_err;
      end else begin
        r_rdata <= r_rdata;
        r_error <= r_error;
      end
    end
  end

  assign bus.req_ready_o = (r_state == IDLE);
  assign bus.rsp_valid_o = (r_state == RESP);
  assign bus.rsp_rdata_o = r_rdata;
  assign bus.rsp_error_o = r_error;

endmodule

// File: tb/tb_carfield_mailbox_responder.sv
// tb_carfield_mailbox_responder
// Directed self-checking bench for the mailbox responder.
module tb_carfield_mailbox_responder;

  logic       clk;
  logic       rst;
  logic [3:0] rcv_irq;
  logic [3:0] snd_irq;
  int         checks;
  int         failures;
  logic [31:0] rd;
  logic        er;

  carfield_mailbox_responder_if #(.AddrWidth(48)) bus ();

  carfield_mailbox_responder #(
    .NumMbox   (4),
    .AddrWidth (48)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus.slave),
    .rcv_irq_o (rcv_irq),
    .snd_irq_o (snd_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction with rsp_ready_i held high; returns in the response cycle.
  task automatic access(input string tag, input logic [47:0] a, input logic w,
                        input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rdata, output logic err);
    int n;
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = a;
    bus.req_write_i = w;
    bus.req_wdata_i = d;
    bus.req_wstrb_i = s;
    n = 0;
    while (!bus.req_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, {31'b0, bus.req_ready_o}, 32'h1);
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    @(negedge clk);
    check({tag, "_rvalid"}, {31'b0, bus.rsp_valid_o}, 32'h1);
    rdata = bus.rsp_rdata_o;
    err   = bus.rsp_error_o;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = 48'h0;
    bus.req_write_i = 1'b0;
    bus.req_wdata_i = 32'h0;
    bus.req_wstrb_i = 4'h0;
    bus.rsp_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_req_ready", {31'b0, bus.req_ready_o}, 32'h1);
    check("rst_rsp_valid", {31'b0, bus.rsp_valid_o}, 32'h0);
    check("rst_rdata", bus.rsp_rdata_o, 32'h0);
    check("rst_error", {31'b0, bus.rsp_error_o}, 32'h0);
    check("rst_irqs", {24'b0, rcv_irq, snd_irq}, 32'h0);

    // Letter write/read with byte strobes
    access("wr_l0", 48'h4000_0100, 1'b1, 32'hDEAD_BEEF, 4'hF, rd, er);
    check("wr_l0_rdata", rd, 32'h0);
    check("wr_l0_err", {31'b0, er}, 32'h0);
    access("rd_l0", 48'h4000_0100, 1'b0, 32'h0, 4'h0, rd, er);
    check("rd_l0_rdata", rd, 32'hDEAD_BEEF);
    check("rd_l0_err", {31'b0, er}, 32'h0);
    access("wr_l0b", 48'h4000_0100, 1'b1, 32'h1122_3344, 4'b0101, rd, er);
    access("rd_l0b", 48'h4000_0100, 1'b0, 32'h0, 4'h0, rd, er);
    check("rd_l0b_rdata", rd, 32'hDE22_BE44);
    access("wr_l1", 48'h4000_0104, 1'b1, 32'hCAFE_F00D, 4'h0, rd, er);
    access("rd_l1", 48'h4000_0104, 1'b0, 32'h0, 4'h0, rd, er);
    check("rd_l1_nostrb", rd, 32'h0);

    // IRQ flow on mailbox 2
    access("en2", 48'h4000_0210, 1'b1, 32'h3, 4'hF, rd, er);
    access("db2", 48'h4000_0208, 1'b1, 32'h1, 4'hF, rd, er);
    check("db2_rcv_irq", {28'b0, rcv_irq}, 32'h4);
    check("db2_snd_irq", {28'b0, snd_irq}, 32'h0);
    access("cp2", 48'h4000_020C, 1'b1, 32'h1, 4'hF, rd, er);
    check("cp2_rcv_irq", {28'b0, rcv_irq}, 32'h0);
    check("cp2_snd_irq", {28'b0, snd_irq}, 32'h4);
    access("dc2", 48'h4000_0214, 1'b1, 32'h1, 4'hF, rd, er);
    check("dc2_snd_irq", {28'b0, snd_irq}, 32'h0);
    access("rd_en2", 48'h4000_0210, 1'b0, 32'h0, 4'h0, rd, er);
    check("rd_en2", rd, 32'h3);
    access("rd_dc2", 48'h4000_0214, 1'b0, 32'h0, 4'h0, rd, er);
    check("rd_dc2_rdata", rd, 32'h0);
    check("rd_dc2_err", {31'b0, er}, 32'h0);

    // Overrun on mailbox 0
    access("db0a", 48'h4000_0008, 1'b1, 32'h1, 4'h1, rd, er);
    access("db0b", 48'h4000_0008, 1'b1, 32'h1, 4'h1, rd, er);
    check("db0_rcv_irq_masked", {28'b0, rcv_irq}, 32'h0);
    access("rd_db0", 48'h4000_0008, 1'b0, 32'h0, 4'h0, rd, er);
    check("rd_db0_overrun", rd, 32'h3);
    access("cp0", 48'h4000_000C, 1'b1, 32'h2, 4'h1, rd, er);
    access("rd_db0c", 48'h4000_0008, 1'b0, 32'h0, 4'h0, rd, er);
    check("rd_db0_ovr_clr", rd, 32'h1);
    access("rd_cp0", 48'h4000_000C, 1'b0, 32'h0, 4'h0, rd, er);
    check("rd_cp0_done", rd, 32'h0);

    // Decode errors
    access("e_mbox4", 48'h4000_0400, 1'b0, 32'h0, 4'h0, rd, er);
    check("e_mbox4_err", {31'b0, er}, 32'h1);
    check("e_mbox4_rdata", rd, 32'h0);
    access("e_unmap", 48'h4000_0018, 1'b0, 32'h0, 4'h0, rd, er);
    check("e_unmap_err", {31'b0, er}, 32'h1);
    access("e_misal", 48'h4000_0002, 1'b1, 32'hDEAD_BEEF, 4'hF, rd, er);
    check("e_misal_err", {31'b0, er}, 32'h1);
    access("e_below", 48'h3FFF_FFFC, 1'b1, 32'h1234_5678, 4'hF, rd, er);
    check("e_below_err", {31'b0, er}, 32'h1);
    check("e_below_rdata", rd, 32'h0);
    access("e_above", 48'h4000_1000, 1'b0, 32'h0, 4'h0, rd, er);
    check("e_above_err", {31'b0, er}, 32'h1);
    access("rd_l0m0", 48'h4000_0000, 1'b0, 32'h0, 4'h0, rd, er);
    check("e_nochange", rd, 32'h0);

    // Backpressure: response held, second request stalled
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 48'h4000_0100;
    bus.req_write_i = 1'b0;
    @(posedge clk);
    #1 bus.req_addr_i = 48'h4000_0210;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", {31'b0, bus.rsp_valid_o}, 32'h1);
      check("bp_rdata", bus.rsp_rdata_o, 32'hDE22_BE44);
      check("bp_error", {31'b0, bus.rsp_error_o}, 32'h0);
      check("bp_req_ready", {31'b0, bus.req_ready_o}, 32'h0);
    end
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    check("bp_after_hs_ready", {31'b0, bus.req_ready_o}, 32'h1);
    check("bp_after_hs_valid", {31'b0, bus.rsp_valid_o}, 32'h0);
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    @(negedge clk);
    check("bp_second_valid", {31'b0, bus.rsp_valid_o}, 32'h1);
    check("bp_second_rdata", bus.rsp_rdata_o, 32'h3);

    // Reset during RESP with mailbox 2 pending
    access("db2b", 48'h4000_0208, 1'b1, 32'h1, 4'h1, rd, er);
    check("db2b_rcv_irq", {28'b0, rcv_irq}, 32'h4);
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 48'h4000_0208;
    bus.req_write_i = 1'b0;
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    @(negedge clk);
    check("rr_valid", {31'b0, bus.rsp_valid_o}, 32'h1);
    check("rr_rdata", bus.rsp_rdata_o, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("rr_rsp_valid", {31'b0, bus.rsp_valid_o}, 32'h0);
    check("rr_req_ready", {31'b0, bus.req_ready_o}, 32'h1);
    check("rr_irqs", {24'b0, rcv_irq, snd_irq}, 32'h0);
    rst = 1'b0;
    bus.rsp_ready_i = 1'b1;
    access("rr_db2", 48'h4000_0208, 1'b0, 32'h0, 4'h0, rd, er);
    check("rr_db2_rdata", rd, 32'h0);
    access("rr_l0", 48'h4000_0100, 1'b0, 32'h0, 4'h0, rd, er);
    check("rr_l0_rdata", rd, 32'h0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
